// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: green/yellow/all-red sequencer with round-robin service of side approaches.
// Ports: clk, rst (sync, active-high), req[N], lights[3N], grant_idx, phase, pending[N]. Optional macro: GREEN_EXT_EN.
module intersection_phase_scheduler #(
  parameter int N_APPR   = 4,
  parameter int CLK_HZ   = 50000000,
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int EXT_S    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_APPR-1:0]           req,
  output logic [3*N_APPR-1:0]         lights,
  output logic [$clog2(N_APPR)-1:0]   grant_idx,
  output logic [1:0]                  phase,
  output logic [N_APPR-1:0]           pending
);

  localparam int GW = $clog2(N_APPR);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
`ifdef GREEN_EXT_EN
  localparam int EXT_ON = 1;
`else
  localparam int EXT_ON = 0;
`endif
  localparam int GEXT = GREEN_S + EXT_S * EXT_ON;
  localparam int TM1  = (GEXT > YELLOW_S) ? GEXT : YELLOW_S;
  localparam int TMAX = (TM1 > ALLRED_S) ? TM1 : ALLRED_S;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } phase_t;

  phase_t              r_phase;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_rr;
  logic [N_APPR-1:0]   r_pending;
  logic [PW-1:0]       r_pre;
  logic [TW-1:0]       r_timer;
  logic [3*N_APPR-1:0] r_lights;
`ifdef GREEN_EXT_EN
  logic                r_ext;
  logic                w_ext_set;
  logic                w_end_x;
`endif

  phase_t              w_phase_n;
  logic [GW-1:0]       w_grant_n;
  logic [GW-1:0]       w_rr_n;
  logic                w_enter;
  logic                w_tick;
  logic                w_end_g;
  logic                w_end_y;
  logic                w_end_a;
  logic                w_home_ok;
  logic                w_found;
  logic [GW-1:0]       w_sel;
  logic [N_APPR-1:0]   w_set;
  logic [N_APPR-1:0]   w_clr;
  logic [3*N_APPR-1:0] w_lights_n;
  logic [3*N_APPR-1:0] w_lights_home;

  // A phase ends on the tick that would bring the timer to its duration.
  assign w_tick    = (r_pre == PW'(CLK_HZ - 1));
  assign w_end_g   = w_tick && (r_timer == TW'(GREEN_S - 1));
  assign w_end_y   = w_tick && (r_timer == TW'(YELLOW_S - 1));
  assign w_end_a   = w_tick && (r_timer == TW'(ALLRED_S - 1));
  assign w_home_ok = (r_timer >= TW'(GREEN_S)) || w_end_g;
`ifdef GREEN_EXT_EN
  assign w_end_x   = w_tick && (r_timer == TW'(GEXT - 1));
`endif

  // Round-robin pick: upward from rr+1, wrapping, rr itself last.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= N_APPR; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= N_APPR) idx = idx - N_APPR;
      if (!w_found && idx != 0 && r_pending[idx]) begin
        w_found = 1'b1;
        w_sel   = GW'(idx);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_phase_n = r_phase;
    w_grant_n = r_grant;
    w_rr_n    = r_rr;
    w_enter   = 1'b0;
`ifdef GREEN_EXT_EN
    w_ext_set = 1'b0;
`endif
    unique case (r_phase)
      GREEN: begin
        if (r_grant == '0) begin
          if (w_home_ok && (|r_pending)) begin
            w_phase_n = YELLOW;
            w_enter   = 1'b1;
          end
        end else begin
`ifdef GREEN_EXT_EN
          if (!r_ext && w_end_g && req[r_grant]) begin
            w_ext_set = 1'b1;
          end else if ((!r_ext && w_end_g) || (r_ext && w_end_x)) begin
            w_phase_n = YELLOW;
            w_enter   = 1'b1;
          end
`else
          if (w_end_g) begin
            w_phase_n = YELLOW;
            w_enter   = 1'b1;
          end
`endif
        end
      end
      YELLOW: begin
        if (w_end_y) begin
          w_phase_n = ALLRED;
          w_enter   = 1'b1;
        end
      end
      ALLRED: begin
        if (w_end_a) begin
          w_phase_n = GREEN;
          w_enter   = 1'b1;
          w_grant_n = w_found ? w_sel : '0;
          w_rr_n    = w_found ? w_sel : r_rr;
        end
      end
      default: begin
        w_phase_n = GREEN;
        w_grant_n = '0;
        w_enter   = 1'b1;
      end
    endcase
  end

  // Request latch: the approach currently green cannot re-request itself.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 1; i < N_APPR; i++) begin
      w_set[i] = req[i] && !(r_phase == GREEN && r_grant == GW'(i));
    end
    if (r_phase == ALLRED && w_end_a && w_found) w_clr[w_sel] = 1'b1;
  end

  // Output logic: next lights from the current phase register.
  always_comb begin
    w_lights_n    = '0;
    w_lights_home = '0;
    for (int i = 0; i < N_APPR; i++) begin
      w_lights_home[3*i +: 3] = (i == 0) ? 3'b001 : 3'b100;
      if (r_grant == GW'(i) && r_phase == GREEN)
        w_lights_n[3*i +: 3] = 3'b001;
      else if (r_grant == GW'(i) && r_phase == YELLOW)
        w_lights_n[3*i +: 3] = 3'b010;
      else
        w_lights_n[3*i +: 3] = 3'b100;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase   <= GREEN;
      r_grant   <= '0;
      r_rr      <= '0;
      r_pending <= '0;
      r_pre     <= '0;
      r_timer   <= '0;
      r_lights  <= w_lights_home;
`ifdef GREEN_EXT_EN
      r_ext     <= 1'b0;
`endif
    end else begin
      r_phase   <= w_phase_n;
      r_grant   <= w_grant_n;
      r_rr      <= w_rr_n;
      r_pending <= (r_pending | w_set) & ~w_clr;
      r_lights  <= w_lights_n;
      if (w_enter || w_tick) r_pre <= '0;
      else                   r_pre <= r_pre + 1'b1;
      if (w_enter)
        r_timer <= '0;
      else if (w_tick && r_timer != TW'(TMAX))
        r_timer <= r_timer + 1'b1;
`ifdef GREEN_EXT_EN
      if (w_enter)        r_ext <= 1'b0;
      else if (w_ext_set) r_ext <= 1'b1;
`endif
    end
  end

  assign lights    = r_lights;
  assign grant_idx = r_grant;
  assign phase     = r_phase;
  assign pending   = r_pending;

endmodule
